// File: rtl/ssd_pkg.sv
// Shared glyph codes, segment patterns and converter state encoding for the SSD scan driver.
package ssd_pkg;

  localparam int unsigned GLYPH_W = 5;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned IDX_W   = 3;

  localparam logic [GLYPH_W-1:0] GLYPH_BLANK = 5'h10;
  localparam logic [GLYPH_W-1:0] GLYPH_MINUS = 5'h11;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'b1111110;

  localparam logic [1:0] CNV_IDLE   = 2'd0;
  localparam logic [1:0] CNV_SHIFT  = 2'd1;
  localparam logic [1:0] CNV_COMMIT = 2'd2;

  // Active-low {a,b,c,d,e,f,g} pattern for a glyph code.
  function automatic logic [SEG_W-1:0] glyph_to_seg(input logic [GLYPH_W-1:0] g);
    case (g)
      5'h00:   return 7'b0000001;
      5'h01:   return 7'b1001111;
      5'h02:   return 7'b0010010;
      5'h03:   return 7'b0000110;
      5'h04:   return 7'b1001100;
      5'h05:   return 7'b0100100;
      5'h06:   return 7'b0100000;
      5'h07:   return 7'b0001111;
      5'h08:   return 7'b0000000;
      5'h09:   return 7'b0000100;
      5'h0A:   return 7'b0001000;
      5'h0B:   return 7'b1100000;
      5'h0C:   return 7'b0110001;
      5'h0D:   return 7'b1000010;
      5'h0E:   return 7'b0110000;
      5'h0F:   return 7'b0111000;
      5'h11:   return SEG_MINUS;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [31:0] pow10(input int unsigned n);
    logic [31:0] r;
    r = 32'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 32'd10;
    return r;
  endfunction

endpackage

// File: rtl/ssd_bin2bcd.sv
// Sequential double-dabble binary-to-decimal converter producing display glyphs
// with leading-zero blanking and overflow (all minus) flagging.
module ssd_bin2bcd
  import ssd_pkg::*;
#(
  parameter int unsigned BIN_W      = 10,
  parameter int unsigned BCD_DIGITS = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            bin_valid,
  input  logic [BIN_W-1:0]                bin_value,
  input  logic [IDX_W-1:0]                bin_base,
  output logic                            bin_ready,
  output logic                            commit_c,
  output logic [IDX_W-1:0]                commit_base,
  output logic [BCD_DIGITS*GLYPH_W-1:0]   commit_glyphs_c
);

  localparam int unsigned BCD_W = 4 * BCD_DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [31:0] LIMIT = pow10(BCD_DIGITS);

  logic [1:0]       state_q, state_d;
  logic [BIN_W-1:0] sr_q;
  logic [BCD_W-1:0] bcd_q, bcd_d, adj_c;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             all_zero;
  logic [3:0]       digit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= CNV_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    commit_c = 1'b0;
    case (state_q)
      CNV_IDLE:   if (bin_valid) state_d = CNV_SHIFT;
      CNV_SHIFT:  if (cnt_q == CNT_W'(BIN_W - 1)) state_d = CNV_COMMIT;
      CNV_COMMIT: begin
        commit_c = 1'b1;
        state_d  = CNV_IDLE;
      end
      default:    state_d = CNV_IDLE;
    endcase
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
  always_comb begin
    adj_c = bcd_q;
    for (int k = 0; k < int'(BCD_DIGITS); k++) begin
      if (adj_c[4*k +: 4] >= 4'd5) adj_c[4*k +: 4] = adj_c[4*k +: 4] + 4'd3;
    end
    bcd_d = {adj_c[BCD_W-2:0], sr_q[BIN_W-1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q        <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      commit_base <= '0;
      bin_ready   <= 1'b1;
    end else begin
      bin_ready <= (state_d == CNV_IDLE);
      if (state_q == CNV_IDLE && bin_valid) begin
        sr_q        <= bin_value;
        bcd_q       <= '0;
        cnt_q       <= '0;
        ovf_q       <= (32'(bin_value) >= LIMIT);
        commit_base <= bin_base;
      end else if (state_q == CNV_SHIFT) begin
        sr_q  <= sr_q << 1;
        bcd_q <= bcd_d;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Walk from the most significant digit down, blanking zeros until a non-zero digit.
  always_comb begin
    commit_glyphs_c = '0;
    all_zero        = 1'b1;
    digit           = 4'd0;
    for (int k = int'(BCD_DIGITS) - 1; k >= 0; k--) begin
      digit    = bcd_q[4*k +: 4];
      all_zero = all_zero && (digit == 4'd0);
      if (ovf_q)                  commit_glyphs_c[GLYPH_W*k +: GLYPH_W] = GLYPH_MINUS;
      else if (k > 0 && all_zero) commit_glyphs_c[GLYPH_W*k +: GLYPH_W] = GLYPH_BLANK;
      else                        commit_glyphs_c[GLYPH_W*k +: GLYPH_W] = {1'b0, digit};
    end
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment driver with per-digit glyph/dp registers and PWM dimming.
// Define SSD_BCD_EN to compile in the binary-to-decimal score converter.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DIM_W      = 4,
  parameter int unsigned BIN_W      = 10,
  parameter int unsigned BCD_DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_digit,
  input  logic [GLYPH_W-1:0]    wr_glyph,
  input  logic                  wr_dp,
  input  logic [DIM_W-1:0]      brightness,
  input  logic                  bin_valid,
  output logic                  bin_ready,
  input  logic [BIN_W-1:0]      bin_value,
  input  logic [IDX_W-1:0]      bin_base,
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp
);

  logic [DIV_W-1:0]              phase_q;
  logic [IDX_W-1:0]              idx_q;
  logic [GLYPH_W-1:0]            glyph_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]         dp_q;
  logic                          commit_c;
  logic [IDX_W-1:0]              commit_base;
  logic [BCD_DIGITS*GLYPH_W-1:0] commit_glyphs_c;
  logic [GLYPH_W-1:0]            cur_glyph;
  logic                          cur_dp;
  logic                          lit;
  logic [NUM_DIGITS-1:0]         an_d;

`ifdef SSD_BCD_EN
  ssd_bin2bcd #(
    .BIN_W      (BIN_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_bin2bcd (
    .clk             (clk),
    .reset           (reset),
    .bin_valid       (bin_valid),
    .bin_value       (bin_value),
    .bin_base        (bin_base),
    .bin_ready       (bin_ready),
    .commit_c        (commit_c),
    .commit_base     (commit_base),
    .commit_glyphs_c (commit_glyphs_c)
  );
`else
  logic unused_bcd;
  assign unused_bcd      = ^{bin_valid, bin_value, bin_base};
  assign bin_ready       = 1'b0;
  assign commit_c        = 1'b0;
  assign commit_base     = '0;
  assign commit_glyphs_c = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
      idx_q   <= '0;
    end else begin
      phase_q <= phase_q + DIV_W'(1);
      if (phase_q == '1)
        idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Converter results land first; a same-cycle host write to a digit overrides them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < int'(NUM_DIGITS); d++) glyph_q[d] <= GLYPH_BLANK;
      dp_q <= '0;
    end else begin
      for (int d = 0; d < int'(NUM_DIGITS); d++) begin
        for (int k = 0; k < int'(BCD_DIGITS); k++) begin
          if (commit_c && (4'(commit_base) + 4'(k) == 4'(d)))
            glyph_q[d] <= commit_glyphs_c[GLYPH_W*k +: GLYPH_W];
        end
        if (wr_en && wr_digit == IDX_W'(d)) begin
          glyph_q[d] <= wr_glyph;
          dp_q[d]    <= wr_dp;
        end
      end
    end
  end

  always_comb begin
    cur_glyph = GLYPH_BLANK;
    cur_dp    = 1'b0;
    an_d      = '1;
    lit       = (brightness == '1) || (phase_q[DIV_W-1 -: DIM_W] < brightness);
    for (int d = 0; d < int'(NUM_DIGITS); d++) begin
      if (idx_q == IDX_W'(d)) begin
        cur_glyph = glyph_q[d];
        cur_dp    = dp_q[d];
        an_d[d]   = ~lit;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= glyph_to_seg(cur_glyph);
      dp  <= ~cur_dp;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: cycle-count based display model plus directed literal checks.
module tb_ssd_scan_driver;

  localparam int unsigned ND     = 4;
  localparam int unsigned DIV_W  = 6;
  localparam int unsigned DIM_W  = 4;
  localparam int unsigned BIN_W  = 10;
  localparam int unsigned BCD    = 2;
  localparam int          SLOT   = 1 << DIV_W;
  localparam int          PSTEP  = 1 << (DIV_W - DIM_W);
`ifdef SSD_BCD_EN
  localparam bit BCD_EN = 1'b1;
`else
  localparam bit BCD_EN = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             wr_en;
  logic [2:0]       wr_digit;
  logic [4:0]       wr_glyph;
  logic             wr_dp;
  logic [DIM_W-1:0] brightness;
  logic             bin_valid;
  logic             bin_ready;
  logic [BIN_W-1:0] bin_value;
  logic [2:0]       bin_base;
  logic [ND-1:0]    an;
  logic [6:0]       seg;
  logic             dp;

  ssd_scan_driver #(
    .NUM_DIGITS (ND),
    .DIV_W      (DIV_W),
    .DIM_W      (DIM_W),
    .BIN_W      (BIN_W),
    .BCD_DIGITS (BCD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_digit   (wr_digit),
    .wr_glyph   (wr_glyph),
    .wr_dp      (wr_dp),
    .brightness (brightness),
    .bin_valid  (bin_valid),
    .bin_ready  (bin_ready),
    .bin_value  (bin_value),
    .bin_base   (bin_base),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic logic [6:0] seg_of(input logic [4:0] g);
    case (g)
      5'h00: return 7'b0000001;  5'h01: return 7'b1001111;
      5'h02: return 7'b0010010;  5'h03: return 7'b0000110;
      5'h04: return 7'b1001100;  5'h05: return 7'b0100100;
      5'h06: return 7'b0100000;  5'h07: return 7'b0001111;
      5'h08: return 7'b0000000;  5'h09: return 7'b0000100;
      5'h0A: return 7'b0001000;  5'h0B: return 7'b1100000;
      5'h0C: return 7'b0110001;  5'h0D: return 7'b1000010;
      5'h0E: return 7'b0110000;  5'h0F: return 7'b0111000;
      5'h11: return 7'b1111110;
      default: return 7'b1111111;
    endcase
  endfunction

  // Model state: edges since reset, digit contents, pending conversion.
  logic [4:0] m_glyph [ND];
  logic [ND-1:0] m_dp;
  int  k_edges;
  bit  m_ready, pend, rdy_pre, lit;
  int  commit_at, c_val, c_base, ph, pp, idx, n;
  logic [ND-1:0] exp_an;
  logic [6:0]    exp_seg;
  logic          exp_dp;

  task automatic model_reset();
    k_edges = 0;
    pend    = 1'b0;
    m_ready = BCD_EN;
    m_dp    = '0;
    for (int i = 0; i < int'(ND); i++) m_glyph[i] = 5'h10;
  endtask

  task automatic apply_commit();
    int dig;
    logic [4:0] g;
    for (int j = 0; j < int'(BCD); j++) begin
      dig = c_base + j;
      if (c_val >= 10 ** BCD)               g = 5'h11;
      else if (j > 0 && c_val < 10 ** j)    g = 5'h10;
      else                                  g = 5'((c_val / (10 ** j)) % 10);
      if (dig < int'(ND)) m_glyph[dig] = g;
    end
  endtask

  // Every cycle: outputs after an edge reflect the model state held just before that edge.
  always @(posedge clk) begin
    if (reset) begin
      model_reset();
      exp_an  = '1;
      exp_seg = 7'b1111111;
      exp_dp  = 1'b1;
    end else begin
      ph  = k_edges % SLOT;
      pp  = ph / PSTEP;
      idx = (k_edges / SLOT) % int'(ND);
      lit = (brightness == '1) || (pp < int'(brightness));
      exp_an  = lit ? ~(ND'(1) << idx) : '1;
      exp_seg = seg_of(m_glyph[idx]);
      exp_dp  = ~m_dp[idx];
      n       = k_edges + 1;
      rdy_pre = m_ready;
      if (pend && n == commit_at) begin
        apply_commit();
        pend    = 1'b0;
        m_ready = 1'b1;
      end
      if (BCD_EN && rdy_pre && bin_valid) begin
        pend      = 1'b1;
        commit_at = n + int'(BIN_W) + 1;
        c_val     = int'(bin_value);
        c_base    = int'(bin_base);
        m_ready   = 1'b0;
      end
      if (wr_en && int'(wr_digit) < int'(ND)) begin
        m_glyph[int'(wr_digit)] = wr_glyph;
        m_dp[int'(wr_digit)]    = wr_dp;
      end
      k_edges = n;
    end
    #2;
    check("pins{an,seg,dp,ready}", 32'({an, seg, dp, bin_ready}),
          32'({exp_an, exp_seg, exp_dp, m_ready}));
  end

  task automatic write(input int d, input logic [4:0] g, input logic p);
    wr_en    = 1'b1;
    wr_digit = 3'(d);
    wr_glyph = g;
    wr_dp    = p;
    @(negedge clk);
    wr_en    = 1'b0;
  endtask

  task automatic start_conv(input int v, input int b);
    bin_value = BIN_W'(v);
    bin_base  = 3'(b);
    bin_valid = 1'b1;
    @(negedge clk);
    bin_valid = 1'b0;
  endtask

  task automatic wait_an(input logic [ND-1:0] t);
    int w;
    w = 0;
    while (an !== t && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (w >= 400) begin
      checks++;
      $display("FAIL wait_an timeout: an=%b required %b", an, t);
    end
  endtask

  logic [ND-1:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0]    seg_tab [4] = '{7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
  logic          dp_tab  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int cnt;
    reset = 1'b1; wr_en = 1'b0; wr_digit = '0; wr_glyph = '0; wr_dp = 1'b0;
    brightness = '0; bin_valid = 1'b0; bin_value = '0; bin_base = '0;
    repeat (3) @(negedge clk);
    check("reset_an", 32'(an), 32'(4'hF));
    check("reset_seg", 32'(seg), 32'(7'h7F));
    check("reset_dp", 32'(dp), 32'(1));
    check("reset_ready", 32'(bin_ready), 32'(BCD_EN));

    reset = 1'b0;
    brightness = '1;
    for (int d = 0; d < 4; d++) write(d, 5'(d + 1), (d == 2));
    write(5, 5'h08, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_an(an_tab[i]);
      check($sformatf("scan_seg_%0d", i), 32'(seg), 32'(seg_tab[i]));
      check($sformatf("scan_dp_%0d", i), 32'(dp), 32'(dp_tab[i]));
    end

    brightness = 4'd4;
    repeat (2) @(negedge clk);
    cnt = 0;
    repeat (128) begin
      if (an != '1) cnt++;
      @(negedge clk);
    end
    check("duty_4_of_16", 32'(cnt), 32'(32));
    brightness = 4'd0;
    repeat (2) @(negedge clk);
    cnt = 0;
    repeat (64) begin
      if (an != '1) cnt++;
      @(negedge clk);
    end
    check("duty_dark", 32'(cnt), 32'(0));
    brightness = '1;

    start_conv(7, 0);
    cnt = 0;
    while (bin_ready === 1'b0 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
`ifdef SSD_BCD_EN
    check("ready_low_cycles", 32'(cnt), 32'(BIN_W + 1));
`else
    check("ready_tied_low", 32'(cnt), 32'(100));
`endif
    wait_an(4'b1110);
    check("conv7_d0", 32'(seg), BCD_EN ? 32'(7'b0001111) : 32'(7'b1001111));
    wait_an(4'b1101);
    check("conv7_d1", 32'(seg), BCD_EN ? 32'(7'b1111111) : 32'(7'b0010010));

    start_conv(100, 0);
    repeat (BIN_W + 3) @(negedge clk);
    wait_an(4'b1110);
    check("ovf_d0", 32'(seg), BCD_EN ? 32'(7'b1111110) : 32'(7'b1001111));
    wait_an(4'b1101);
    check("ovf_d1", 32'(seg), BCD_EN ? 32'(7'b1111110) : 32'(7'b0010010));

    start_conv(42, 0);
    repeat (BIN_W) @(negedge clk);
    write(0, 5'h0A, 1'b0);
    repeat (2) @(negedge clk);
    wait_an(4'b1110);
    check("collide_d0", 32'(seg), 32'(7'b0001000));
    wait_an(4'b1101);
    check("collide_d1", 32'(seg), BCD_EN ? 32'(7'b1001100) : 32'(7'b0010010));

    start_conv(55, 2);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_an", 32'(an), 32'(4'hF));
    check("midreset_seg", 32'(seg), 32'(7'h7F));
    reset = 1'b0;
    #1;
    check("midreset_ready", 32'(bin_ready), 32'(BCD_EN));
    repeat (BIN_W + 5) @(negedge clk);
    wait_an(4'b1011);
    check("midreset_d2", 32'(seg), 32'(7'b1111111));
    wait_an(4'b0111);
    check("midreset_d3", 32'(seg), 32'(7'b1111111));

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
